sign_narrow: RTL
================

Name: sign_narrow

Overview:
- Inverse of the datapath's 16-to-32 sign extension: narrows 32-bit signed values to 16-bit signed immediates.
- Used on the immediate/store-halfword path of the CPU datapath and in trace/debug packing.
- Streams words through a valid/ready handshake with one registered output stage and a one-entry skid buffer.
- Flags unrepresentable values, optionally saturates them, and keeps a saturating overflow event counter.

Parameters:
- IN_W, 32: input word width.
- OUT_W, 16: output width; must be < IN_W.
- SATURATE, 1: 1 = clamp out-of-range values; 0 = plain truncation.
- CNT_W, 8: overflow counter width.

Ports:
- clk_i  input  1  system clock; all state changes on the rising edge.
- rst_i  input  1  reset; asynchronous, active-low.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  block can accept a word.
- data_i  input  IN_W  signed word to narrow.
- valid_o  output  1  data_o and fits_o are valid.
- ready_i  input  1  downstream accepts the current output.
- data_o  output  OUT_W  narrowed signed value.
- fits_o  output  1  1 = value was representable in OUT_W bits.
- clr_cnt_i  input  1  synchronous clear of ovf_cnt_o.
- ovf_cnt_o  output  CNT_W  number of accepted non-fitting words, saturating.

Behaviour:
- Accept = valid_i & ready_o. Emit = valid_o & ready_i.
- Fit rule: fits iff data_i[IN_W-1:OUT_W-1] are all equal (all zeros or all ones).
- Result when fits: data_i[OUT_W-1:0].
- Result when not fitting, SATURATE=1:
  - data_i[IN_W-1]=0 -> 0x7FFF (max positive, generalised to OUT_W).
  - data_i[IN_W-1]=1 -> 0x8000 (min negative).
- Result when not fitting, SATURATE=0: data_i[OUT_W-1:0] (truncation).
- Result and fit flag are computed combinationally at input and stored together in the output register or the skid register.
- State machine:
  - EMPTY: valid_o=0, ready_o=1. Accept -> load output register -> ONE.
  - ONE: valid_o=1, skid empty, ready_o=1.
    - Accept and emit -> load output register, stay ONE.
    - Emit only -> EMPTY.
    - Accept only -> load skid -> FULL.
  - FULL: valid_o=1, skid full, ready_o=0.
    - Emit -> move skid into output register -> ONE.
- ready_o is driven from a register (state != FULL); it has no combinational path from ready_i.
- Latency: one cycle from accept to valid_o when the output stage is empty.
- Throughput: 1 word/cycle while ready_i=1.
- Ordering: words leave in acceptance order; no loss and no duplication under any ready_i pattern.
- data_o and fits_o hold stable while valid_o=1 and ready_i=0.
- Counter:
  - Increments on each accepted word with fits=0.
  - Saturates at 2^CNT_W-1 and never wraps.
  - clr_cnt_i has priority: when clear and an overflow accept coincide, the counter becomes 0.
- Reset values (rst_i low, effective immediately, no clock edge needed): state EMPTY, valid_o=0, ready_o=1, data_o=0, fits_o=0, ovf_cnt_o=0, skid contents 0.
- Reset mid-operation discards all buffered words.
- valid_i while ready_o=0 is ignored; the upstream must hold data_i.

Test Plan:
1. Reset: drive rst_i=0 with random inputs -> valid_o=0, ready_o=1, data_o=0x0000, fits_o=0, ovf_cnt_o=0. Release reset -> values unchanged until the first accept.
2. In-range values: accept 0xFFFF8000, then 0x00007FFF, with ready_i=1 -> on the next cycles data_o=0x8000 fits_o=1, then data_o=0x7FFF fits_o=1; ovf_cnt_o=0.
3. Out-of-range values:
   - SATURATE=1: accept 0x00008000 -> data_o=0x7FFF, fits_o=0, ovf_cnt_o=1. Accept 0x80000000 -> data_o=0x8000, fits_o=0, ovf_cnt_o=2.
   - SATURATE=0, same inputs -> data_o=0x8000 then 0x0000, fits_o=0 for both.
4. Backpressure:
   - Hold ready_i=0 and offer 0x1, 0x2, 0x3 back-to-back -> 0x1 and 0x2 accepted, ready_o=0 the cycle after 0x2, 0x3 held upstream.
   - Raise ready_i=1 -> outputs 0x0001, 0x0002, 0x0003 on consecutive cycles; no gaps after the first, no duplicates.
5. Counter limits (CNT_W=8):
   - 260 out-of-range accepts -> ovf_cnt_o=255.
   - Assert clr_cnt_i in the same cycle as an out-of-range accept -> ovf_cnt_o=0 next cycle.
6. Asynchronous reset mid-operation: in FULL state, pull rst_i low between clock edges -> valid_o=0, ready_o=1, ovf_cnt_o=0 immediately. After release, the next accepted 0x5 emerges alone with fits_o=1.

Source files
------------

// File: rtl/sign_narrow_if.sv
// Stream handshake bundle for sign_narrow: upstream word in, narrowed word out.
interface sign_narrow_if #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 16
);
   logic             valid_i;
   logic             ready_o;
   logic [IN_W-1:0]  data_i;
   logic             valid_o;
   logic             ready_i;
   logic [OUT_W-1:0] data_o;
   logic             fits_o;

   modport slave (
      input  valid_i,
      input  data_i,
      input  ready_i,
      output ready_o,
      output valid_o,
      output data_o,
      output fits_o
   );

   modport master (
      output valid_i,
      output data_i,
      output ready_i,
      input  ready_o,
      input  valid_o,
      input  data_o,
      input  fits_o
   );
endinterface

// File: rtl/sign_narrow.sv
// Narrows IN_W-bit signed words to OUT_W bits behind a registered output stage
// with a one-entry skid buffer; flags/saturates unrepresentable values and counts them.
module sign_narrow #(
   parameter int IN_W     = 32,
   parameter int OUT_W    = 16,
   parameter bit SATURATE = 1'b1,
   parameter int CNT_W    = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   sign_narrow_if.slave     bus,
   input  logic             clr_cnt_i,
   output logic [CNT_W-1:0] ovf_cnt_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Representable iff every bit from the sign bit down to bit OUT_W-1 agrees.
   function automatic logic fits_f(input logic [IN_W-1:0] d);
      logic [IN_W-OUT_W:0] top;
      top = d[IN_W-1:OUT_W-1];
      return (&top) | ~(|top);
   endfunction

   function automatic logic [OUT_W-1:0] narrow_f(input logic [IN_W-1:0] d);
      logic [OUT_W-1:0] res;
      if (fits_f(d) || !SATURATE) begin
         res = d[OUT_W-1:0];
      end else if (d[IN_W-1]) begin
         res = MIN_NEG;
      end else begin
         res = MAX_POS;
      end
      return res;
   endfunction

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_valid;
   logic             r_ready;
   logic [OUT_W-1:0] r_data;
   logic             r_fits;
   logic [OUT_W-1:0] r_skid_data;
   logic             r_skid_fits;
   logic [CNT_W-1:0] r_cnt;

   logic             w_acc;
   logic             w_emit;
   logic             w_fits;
   logic [OUT_W-1:0] w_res;
   logic             w_load_out;
   logic             w_load_skid;
   logic             w_out_from_skid;

   assign w_acc  = bus.valid_i & r_ready;
   assign w_emit = r_valid & bus.ready_i;
   assign w_fits = fits_f(bus.data_i);
   assign w_res  = narrow_f(bus.data_i);

   assign bus.ready_o = r_ready;
   assign bus.valid_o = r_valid;
   assign bus.data_o  = r_data;
   assign bus.fits_o  = r_fits;
   assign ovf_cnt_o   = r_cnt;

   // Next-state and load-enable decode for the output/skid pair.
   always_comb begin
      w_state_nxt     = r_state;
      w_load_out      = 1'b0;
      w_load_skid     = 1'b0;
      w_out_from_skid = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_acc) begin
               w_load_out  = 1'b1;
               w_state_nxt = ST_ONE;
            end else begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (w_acc && w_emit) begin
               w_load_out  = 1'b1;
               w_state_nxt = ST_ONE;
            end else if (w_emit) begin
               w_state_nxt = ST_EMPTY;
            end else if (w_acc) begin
               w_load_skid = 1'b1;
               w_state_nxt = ST_FULL;
            end else begin
               w_state_nxt = ST_ONE;
            end
         end
         ST_FULL: begin
            if (w_emit) begin
               w_load_out      = 1'b1;
               w_out_from_skid = 1'b1;
               w_state_nxt     = ST_ONE;
            end else begin
               w_state_nxt = ST_FULL;
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
         end
      endcase
   end

   // State register; valid/ready are registered copies of the next state.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= ST_EMPTY;
         r_valid <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_valid <= (w_state_nxt != ST_EMPTY);
         r_ready <= (w_state_nxt != ST_FULL);
      end
   end

   // Output register; refilled from the skid first so order is preserved.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_data <= {OUT_W{1'b0}};
         r_fits <= 1'b0;
      end else if (w_load_out) begin
         if (w_out_from_skid) begin
            r_data <= r_skid_data;
            r_fits <= r_skid_fits;
         end else begin
            r_data <= w_res;
            r_fits <= w_fits;
         end
      end else begin
         r_data <= r_data;
         r_fits <= r_fits;
      end
   end

   // Skid register captures a word accepted while the output is stalled.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_skid_data <= {OUT_W{1'b0}};
         r_skid_fits <= 1'b0;
      end else if (w_load_skid) begin
         r_skid_data <= w_res;
         r_skid_fits <= w_fits;
      end else begin
         r_skid_data <= r_skid_data;
         r_skid_fits <= r_skid_fits;
      end
   end

   // Saturating overflow counter; clear wins over a coincident increment.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (clr_cnt_i) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (w_acc && !w_fits && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_ONE;
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule
